// File: rtl/m92_pkg.sv
// Shared types for the M92 V30 bus sequencer: bus request and pause FSM states.
// Ports: none (package).
// Latency/backpressure: n/a.
package m92_pkg;

  localparam int BUS_AW = 20;
  localparam int SDR_AW = 25;
  localparam int DW     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2,
    RESUME = 2'd3
  } pause_state_t;

endpackage

// File: rtl/m92_cpu_bus_ctrl_if.sv
// Toggle-handshake SDRAM CPU port: master raises requests, slave answers on ack.
// Ports: sdr_rq/addr/din/wr_sel (master->slave), sdr_ack/sdr_dout (slave->master).
// Backpressure: a request is outstanding until sdr_ack equals sdr_rq.
interface m92_cpu_bus_ctrl_if;
  import m92_pkg::*;

  logic              sdr_rq;
  logic              sdr_ack;
  logic [SDR_AW-1:0] sdr_addr;
  logic [DW-1:0]     sdr_din;
  logic [1:0]        sdr_wr_sel;
  logic [DW-1:0]     sdr_dout;

  modport master (
    output sdr_rq, sdr_addr, sdr_din, sdr_wr_sel,
    input  sdr_ack, sdr_dout
  );

  modport slave (
    input  sdr_rq, sdr_addr, sdr_din, sdr_wr_sel,
    output sdr_ack, sdr_dout
  );

endinterface

// File: rtl/m92_cpu_pause.sv
// Frame-accurate CPU pause: drains the bus, freezes, resumes at the captured V/H position.
// Ports: clk/reset_n, i_pause_rq, i_bus_idle, i_vcount/i_hcount in; o_paused (registered) out.
// Latency: o_paused changes one cycle after the qualifying condition is sampled.
module m92_cpu_pause
  import m92_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_pause_rq,
  input  logic       i_bus_idle,
  input  logic [8:0] i_vcount,
  input  logic [9:0] i_hcount,
  output logic       o_paused
);

  pause_state_t r_state;
  logic [8:0]   r_vcap;
  logic [9:0]   r_hcap;
  logic         r_paused;
  logic         w_pos_match;

  assign w_pos_match = (i_vcount == r_vcap) && (i_hcount == r_hcap);
  assign o_paused    = r_paused;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= RUN;
      r_vcap   <= '0;
      r_hcap   <= '0;
      r_paused <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_pause_rq) r_state <= DRAIN;
        end
        DRAIN: begin
          // A withdrawn request wins over a bus that happens to go idle.
          if (!i_pause_rq) begin
            r_state <= RUN;
          end else if (i_bus_idle) begin
            r_state  <= PAUSED;
            r_vcap   <= i_vcount;
            r_hcap   <= i_hcount;
            r_paused <= 1'b1;
          end
        end
        PAUSED: begin
          if (!i_pause_rq) r_state <= RESUME;
        end
        RESUME: begin
          // CPU stays frozen until the beam returns to the freeze point, so
          // the CPU sees no lost video time across the pause.
          if (i_pause_rq) begin
            r_state <= PAUSED;
          end else if (w_pos_match) begin
            r_state  <= RUN;
            r_paused <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/m92_cpu_bus_ctrl.sv
// V30 bus sequencer: CPU clock enables, stall on SDRAM/VRAM/pause, toggle SDRAM requests.
// Ports: V30 strobes/addr/data, region decode, video counters in; ce_*, mem_*, rom_data,
//        mem_busy, paused out; SDRAM port via m92_cpu_bus_ctrl_if.master. Request launches 1 cycle after strobe.
module m92_cpu_bus_ctrl
  import m92_pkg::*;
#(
  parameter int CE_DIV_LOG2 = 2
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic              pause_rq,
  input  logic [8:0]        vcount,
  input  logic [9:0]        hcount,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [BUS_AW-1:0] bus_addr,
  input  logic [1:0]        bus_be,
  input  logic [DW-1:0]     bus_dout,
  input  logic              ram_rom_memrq,
  input  logic              pf_vram_memrq,
  input  logic [SDR_AW-1:0] region_addr,
  input  logic              region_writable,
  input  logic              ext_busy,
  output logic              ce_cpu,
  output logic              ce_4x_cpu,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DW-1:0]     word_dout,
  output logic [DW-1:0]     rom_data,
  output logic              mem_busy,
  output logic              paused,
  m92_cpu_bus_ctrl_if.master sdr
);

  bus_state_t              r_bus_state;
  logic                    r_read_d1;
  logic                    r_write_d1;
  logic [CE_DIV_LOG2-1:0]  r_ce_cnt;
  logic                    r_sdr_rq;
  logic [SDR_AW-1:0]       r_sdr_addr;
  logic [DW-1:0]           r_sdr_din;
  logic [1:0]              r_sdr_wr_sel;
  logic [DW-1:0]           r_rom_data;
  logic                    r_mem_busy;

  logic                    w_rd_rise;
  logic                    w_wr_rise;
  logic [1:0]              w_lanes;
  logic                    w_stall;
  logic                    w_run;
  logic                    w_paused;
  logic                    w_unused;

  assign mem_read  = bus_read  | r_read_d1;
  assign mem_write = bus_write | r_write_d1;
  assign w_rd_rise = bus_read  & ~r_read_d1;
  assign w_wr_rise = bus_write & ~r_write_d1;

  // Odd-address byte access: the low data byte moves to the high lane.
  assign word_dout = bus_addr[0] ? {bus_dout[7:0], 8'h00} : bus_dout;
  assign w_lanes   = bus_addr[0] ? {bus_be[0], 1'b0}      : bus_be;

  // Combinational so the enable is already suppressed in the strobe cycle.
  assign w_stall = ((ram_rom_memrq | pf_vram_memrq) & (mem_read | mem_write))
                 | r_mem_busy | ext_busy | w_paused;
  assign w_run   = reset_n & ~w_stall;

  assign ce_4x_cpu = w_run;
  assign ce_cpu    = w_run & (&r_ce_cnt);

  assign sdr.sdr_rq     = r_sdr_rq;
  assign sdr.sdr_addr   = r_sdr_addr;
  assign sdr.sdr_din    = r_sdr_din;
  assign sdr.sdr_wr_sel = r_sdr_wr_sel;

  assign rom_data = r_rom_data;
  assign mem_busy = r_mem_busy;
  assign paused   = w_paused;

  assign w_unused = ^bus_addr[BUS_AW-1:1];

  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      r_bus_state  <= IDLE;
      r_read_d1    <= 1'b0;
      r_write_d1   <= 1'b0;
      r_ce_cnt     <= '0;
      r_sdr_rq     <= 1'b0;
      r_sdr_addr   <= '0;
      r_sdr_din    <= '0;
      r_sdr_wr_sel <= 2'b00;
      r_rom_data   <= '0;
      r_mem_busy   <= 1'b0;
    end else begin
      r_read_d1  <= bus_read;
      r_write_d1 <= bus_write;

      if (w_run) r_ce_cnt <= r_ce_cnt + CE_DIV_LOG2'(1);

      case (r_bus_state)
        IDLE: begin
          if ((w_rd_rise | w_wr_rise) & ram_rom_memrq) begin
            r_bus_state <= WAIT;
            r_sdr_addr  <= region_addr;
            r_sdr_rq    <= ~r_sdr_rq;
            r_mem_busy  <= 1'b1;
            // Writes into read-only regions go out as reads so the CPU
            // still sees a normal bus cycle.
            if (w_wr_rise & region_writable) begin
              r_sdr_wr_sel <= w_lanes;
              r_sdr_din    <= word_dout;
            end else begin
              r_sdr_wr_sel <= 2'b00;
            end
          end
        end
        WAIT: begin
          // New strobes are dropped here; the stall keeps the CPU from
          // issuing them in normal operation.
          if (sdr.sdr_ack == r_sdr_rq) begin
            r_bus_state <= IDLE;
            r_rom_data  <= sdr.sdr_dout;
            r_mem_busy  <= 1'b0;
          end
        end
        default: r_bus_state <= IDLE;
      endcase
    end
  end

  m92_cpu_pause u_pause (
    .clk        (CLK_32M),
    .reset_n    (reset_n),
    .i_pause_rq (pause_rq),
    .i_bus_idle (~mem_read & ~mem_write & ~r_mem_busy),
    .i_vcount   (vcount),
    .i_hcount   (hcount),
    .o_paused   (w_paused)
  );

endmodule

// File: tb/tb_m92_cpu_bus_ctrl.sv
module tb_m92_cpu_bus_ctrl;

  logic        CLK_32M = 1'b0;
  logic        reset_n;
  logic        pause_rq;
  logic [8:0]  vcount;
  logic [9:0]  hcount;
  logic        bus_read, bus_write;
  logic [19:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_dout;
  logic        ram_rom_memrq, pf_vram_memrq;
  logic [24:0] region_addr;
  logic        region_writable;
  logic        ext_busy;
  logic        ce_cpu, ce_4x_cpu, mem_read, mem_write;
  logic [15:0] word_dout, rom_data;
  logic        mem_busy, paused;
  logic        sdr_ack;
  logic [15:0] sdr_dout;

  always #5 CLK_32M = ~CLK_32M;

  m92_cpu_bus_ctrl_if sdr ();
  assign sdr.sdr_ack  = sdr_ack;
  assign sdr.sdr_dout = sdr_dout;

  m92_cpu_bus_ctrl #(.CE_DIV_LOG2(2)) dut (
    .CLK_32M         (CLK_32M),
    .reset_n         (reset_n),
    .pause_rq        (pause_rq),
    .vcount          (vcount),
    .hcount          (hcount),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_dout        (bus_dout),
    .ram_rom_memrq   (ram_rom_memrq),
    .pf_vram_memrq   (pf_vram_memrq),
    .region_addr     (region_addr),
    .region_writable (region_writable),
    .ext_busy        (ext_busy),
    .ce_cpu          (ce_cpu),
    .ce_4x_cpu       (ce_4x_cpu),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .word_dout       (word_dout),
    .rom_data        (rom_data),
    .mem_busy        (mem_busy),
    .paused          (paused),
    .sdr             (sdr)
  );

  typedef struct {
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] dout;
    logic        wr_ok;
    logic [15:0] exp_word;
    logic [1:0]  exp_sel;
  } wvec_t;

  typedef struct {
    logic [8:0] v;
    logic [9:0] h;
  } vh_t;

  wvec_t vec [6];
  vh_t   near [3];
  int    n_checks = 0;
  int    n_errors = 0;
  logic  exp_rq;
  int    n_ce;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    @(negedge CLK_32M);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ce_cpu"},     ce_cpu, 0);
    check({tag, " ce_4x_cpu"},  ce_4x_cpu, 0);
    check({tag, " sdr_rq"},     sdr.sdr_rq, 0);
    check({tag, " sdr_wr_sel"}, sdr.sdr_wr_sel, 0);
    check({tag, " sdr_addr"},   sdr.sdr_addr, 0);
    check({tag, " sdr_din"},    sdr.sdr_din, 0);
    check({tag, " rom_data"},   rom_data, 0);
    check({tag, " mem_busy"},   mem_busy, 0);
    check({tag, " paused"},     paused, 0);
    check({tag, " mem_read"},   mem_read, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0] = '{20'h00101, 2'b01, 16'h00AB, 1'b1, 16'hAB00, 2'b10};
    vec[1] = '{20'h00101, 2'b01, 16'h00AB, 1'b0, 16'hAB00, 2'b00};
    vec[2] = '{20'h00200, 2'b11, 16'h1234, 1'b1, 16'h1234, 2'b11};
    vec[3] = '{20'h00203, 2'b11, 16'h5678, 1'b1, 16'h7800, 2'b10};
    vec[4] = '{20'h00205, 2'b10, 16'h9ACD, 1'b1, 16'hCD00, 2'b00};
    vec[5] = '{20'h00206, 2'b10, 16'hFFEE, 1'b1, 16'hFFEE, 2'b10};
    near[0] = '{9'd100, 10'd199};
    near[1] = '{9'd99,  10'd200};
    near[2] = '{9'd100, 10'd201};

    reset_n = 1'b0; pause_rq = 1'b0; vcount = '0; hcount = '0;
    bus_read = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_be = 2'b11; bus_dout = '0;
    ram_rom_memrq = 1'b0; pf_vram_memrq = 1'b0; region_addr = '0; region_writable = 1'b0;
    ext_busy = 1'b0; sdr_ack = 1'b0; sdr_dout = '0;
    exp_rq = 1'b0;

    @(negedge CLK_32M);
    tick();
    tick();
    check_reset_vals("reset");

    // Free-running enables: 4x every cycle, 1x on every 4th
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("run ce_4x", ce_4x_cpu, 1);
      check("run ce_cpu", ce_cpu, ((i % 4) == 3) ? 1 : 0);
      tick();
    end

    // SDRAM read with delayed ack
    bus_addr = 20'h01235; bus_be = 2'b11; bus_read = 1'b1;
    ram_rom_memrq = 1'b1; region_addr = 25'h0012345;
    #1;
    check("rd strobe ce_4x", ce_4x_cpu, 0);
    check("rd strobe mem_read", mem_read, 1);
    tick();
    exp_rq = ~exp_rq;
    check("rd sdr_rq", sdr.sdr_rq, exp_rq);
    check("rd wr_sel", sdr.sdr_wr_sel, 2'b00);
    check("rd sdr_addr", sdr.sdr_addr, 25'h0012345);
    check("rd mem_busy", mem_busy, 1);
    check("rd stretch mem_read", mem_read, 1);
    bus_read = 1'b0; ram_rom_memrq = 1'b0;
    #1;
    check("rd busy ce_4x a", ce_4x_cpu, 0);
    tick();
    check("rd busy ce_4x b", ce_4x_cpu, 0);
    check("rd busy ce_cpu", ce_cpu, 0);
    tick();
    sdr_dout = 16'hBEEF; sdr_ack = exp_rq;
    #1;
    check("rd busy ce_4x c", ce_4x_cpu, 0);
    tick();
    check("rd rom_data", rom_data, 16'hBEEF);
    check("rd done mem_busy", mem_busy, 0);
    check("rd done ce_4x", ce_4x_cpu, 1);

    // Table-driven writes: lane formatting and writable gating
    for (int i = 0; i < 6; i++) begin
      bus_write = 1'b1; bus_addr = vec[i].addr; bus_be = vec[i].be; bus_dout = vec[i].dout;
      ram_rom_memrq = 1'b1; region_addr = 25'h1000000 | 25'(i); region_writable = vec[i].wr_ok;
      #1;
      check($sformatf("wr%0d word_dout", i), word_dout, vec[i].exp_word);
      check($sformatf("wr%0d ce_4x", i), ce_4x_cpu, 0);
      tick();
      exp_rq = ~exp_rq;
      bus_write = 1'b0; ram_rom_memrq = 1'b0;
      check($sformatf("wr%0d sdr_rq", i), sdr.sdr_rq, exp_rq);
      check($sformatf("wr%0d wr_sel", i), sdr.sdr_wr_sel, vec[i].exp_sel);
      check($sformatf("wr%0d sdr_addr", i), sdr.sdr_addr, 25'h1000000 | 25'(i));
      if (vec[i].wr_ok) check($sformatf("wr%0d sdr_din", i), sdr.sdr_din, vec[i].exp_word);
      sdr_ack = exp_rq;
      tick();
      check($sformatf("wr%0d done busy", i), mem_busy, 0);
    end
    region_writable = 1'b0;

    // Strobe during WAIT is dropped; strobe coinciding with ack is not launched
    bus_read = 1'b1; bus_addr = 20'h00400; ram_rom_memrq = 1'b1; region_addr = 25'h0000400;
    tick();
    exp_rq = ~exp_rq;
    bus_read = 1'b0;
    check("ign sdr_rq launch", sdr.sdr_rq, exp_rq);
    tick();
    bus_read = 1'b1; region_addr = 25'h0000777;
    tick();
    bus_read = 1'b0;
    check("ign sdr_rq held", sdr.sdr_rq, exp_rq);
    check("ign sdr_addr held", sdr.sdr_addr, 25'h0000400);
    check("ign busy", mem_busy, 1);
    tick();
    bus_read = 1'b1; sdr_ack = exp_rq; sdr_dout = 16'h1357;
    tick();
    bus_read = 1'b0;
    check("coinc busy", mem_busy, 0);
    check("coinc rom_data", rom_data, 16'h1357);
    check("coinc sdr_rq", sdr.sdr_rq, exp_rq);
    tick();
    check("coinc no launch rq", sdr.sdr_rq, exp_rq);
    check("coinc no launch busy", mem_busy, 0);
    ram_rom_memrq = 1'b0;

    // VRAM read held off by GA23 busy
    bus_read = 1'b1; pf_vram_memrq = 1'b1; ext_busy = 1'b1;
    n_ce = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ce_4x_cpu || ce_cpu) n_ce++;
      tick();
      bus_read = 1'b0;
    end
    check("vram ce pulses", n_ce, 0);
    check("vram sdr_rq", sdr.sdr_rq, exp_rq);
    check("vram busy", mem_busy, 0);
    ext_busy = 1'b0; pf_vram_memrq = 1'b0;
    #1;
    check("vram release ce_4x", ce_4x_cpu, 1);
    tick();

    // Pause during outstanding request, resume at captured V/H
    vcount = 9'd100; hcount = 10'd200;
    bus_read = 1'b1; ram_rom_memrq = 1'b1; region_addr = 25'h0000ABC;
    tick();
    exp_rq = ~exp_rq;
    bus_read = 1'b0; ram_rom_memrq = 1'b0; pause_rq = 1'b1;
    tick();
    check("pz drain a", paused, 0);
    tick();
    check("pz drain b", paused, 0);
    sdr_ack = exp_rq; sdr_dout = 16'h2468;
    tick();
    check("pz ack busy", mem_busy, 0);
    check("pz after ack", paused, 0);
    tick();
    check("pz paused", paused, 1);
    check("pz ce_4x", ce_4x_cpu, 0);
    vcount = 9'd101; hcount = 10'd5; pause_rq = 1'b0;
    tick();
    check("pz resume held", paused, 1);
    for (int i = 0; i < 3; i++) begin
      vcount = near[i].v; hcount = near[i].h;
      tick();
      check($sformatf("pz near%0d", i), paused, 1);
    end
    vcount = 9'd100; hcount = 10'd200;
    #1;
    check("pz match cycle", paused, 1);
    tick();
    check("pz released", paused, 0);
    check("pz released ce_4x", ce_4x_cpu, 1);
    vcount = 9'd0; hcount = 10'd0;

    // Reset during WAIT, then a stray ack
    bus_read = 1'b1; ram_rom_memrq = 1'b1; region_addr = 25'h1FFFFFF;
    tick();
    exp_rq = ~exp_rq;
    bus_read = 1'b0; ram_rom_memrq = 1'b0;
    check("rst pre busy", mem_busy, 1);
    reset_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    reset_n = 1'b1;
    exp_rq = 1'b0;
    sdr_dout = 16'hDEAD; sdr_ack = ~sdr_ack;
    tick();
    tick();
    check("stray rom_data", rom_data, 0);
    check("stray busy", mem_busy, 0);
    check("stray sdr_rq", sdr.sdr_rq, exp_rq);
    check("stray ce_4x", ce_4x_cpu, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m92_cpu_bus_ctrl.md
# m92_cpu_bus_ctrl

Sequencer for the V30 main-CPU bus in the M92 core. It generates the CPU clock enables and stalls them while SDRAM or playfield-VRAM accesses are pending. It converts single-cycle V30 bus strobes into toggle-handshake SDRAM requests with byte-lane formatting. It also implements frame-accurate pause/resume against the video counters. It sits between the `cpu` instance, the address translator, GA23 and the SDRAM CPU port.

## Interface
Parameters:
- CE_DIV_LOG2, 2, log2 of ce_4x_cpu pulses per ce_cpu pulse

Ports:
- CLK_32M  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- pause_rq  in  1  level request to freeze the CPU
- vcount  in  9  current video line
- hcount  in  10  current video pixel
- bus_read, bus_write  in  1  V30 strobes, high for one cycle
- bus_addr  in  20  V30 byte address
- bus_be  in  2  V30 byte enables
- bus_dout  in  16  V30 write data
- ram_rom_memrq  in  1  address decodes to SDRAM region
- pf_vram_memrq  in  1  address decodes to GA23 VRAM
- region_addr  in  25  translated SDRAM address
- region_writable  in  1  region accepts writes
- ext_busy  in  1  GA23 busy
- ce_cpu  out  1  CPU clock enable
- ce_4x_cpu  out  1  CPU 4x clock enable
- mem_read, mem_write  out  1  strobes stretched to two cycles
- word_dout  out  16  lane-aligned write data (combinational)
- sdr_rq  out  1  request toggle
- sdr_ack  in  1  acknowledge toggle, already synchronised to CLK_32M
- sdr_addr  out  25  request address
- sdr_din  out  16  request write data
- sdr_wr_sel  out  2  byte write strobes; 00 = read
- sdr_dout  in  16  read data, valid when sdr_ack == sdr_rq
- rom_data  out  16  last completed SDRAM read word
- mem_busy  out  1  SDRAM request outstanding
- paused  out  1  CPU frozen

## Operation
- **Strobe stretch.** mem_read = bus_read | bus_read_d1. mem_write is formed the same way.
- **Word formatting.**
  - bus_addr[0]=1: word_dout = {bus_dout[7:0],8'h00} and lanes = {bus_be[0],1'b0}.
  - bus_addr[0]=0: pass-through.
- **Request FSM, states IDLE and WAIT.**
  - IDLE → WAIT on a rising bus_read or bus_write (strobe high, _d1 low) with ram_rom_memrq.
  - On that transition: sdr_addr←region_addr; sdr_rq←~sdr_rq; mem_busy←1.
  - sdr_wr_sel←lanes and sdr_din←word_dout only if the access is a write and region_writable. Otherwise sdr_wr_sel←00.
  - WAIT → IDLE when sdr_ack==sdr_rq: rom_data←sdr_dout; mem_busy←0.
  - Strobes arriving in WAIT are ignored.
- **Stall.** Stall when (ram_rom_memrq|pf_vram_memrq)&(mem_read|mem_write), or mem_busy, or ext_busy, or paused.
- **Clock enables.**
  - When not stalled: the counter increments, ce_4x_cpu=1, and ce_cpu=1 when the counter is all-ones before the increment.
  - When stalled: both enables are 0 and the counter holds.
- **Pause FSM, states RUN, DRAIN, PAUSED, RESUME.**
  - RUN → DRAIN on pause_rq.
  - DRAIN → PAUSED when ~mem_read & ~mem_write & ~mem_busy. On that transition, capture vcount/hcount and set paused←1.
  - DRAIN → RUN if pause_rq drops first.
  - PAUSED → RESUME on ~pause_rq.
  - RESUME → RUN when vcount/hcount equal the captured values; paused←0 at that point.
  - RESUME → PAUSED if pause_rq rises again.
- **Reset values.** States IDLE/RUN; sdr_rq=0; sdr_wr_sel=00; sdr_addr=0; sdr_din=0; rom_data=0; mem_busy=0; paused=0; ce counter=0; ce_cpu=ce_4x_cpu=0; strobe delays=0.

## Timing
- Request launch: strobe at edge t; sdr_rq toggles and mem_busy rises at t+1.
- Completion: ack match sampled at edge k; rom_data valid and mem_busy low at k+1. Enables resume at k+1 unless another stall term holds.
- The stall condition is combinational on the current cycle's inputs, so ce_cpu never pulses in the cycle a strobe is seen with a memrq.
- An ack match and a new strobe in the same cycle: completion wins. The new strobe is not launched.
- Reset mid-request: FSM returns to IDLE, and a late sdr_ack toggle is ignored until the next request.
- Counter wraps modulo 2^CE_DIV_LOG2.

## Structure
- m92_pkg: enums bus_state_t {IDLE, WAIT} and pause_state_t {RUN, DRAIN, PAUSED, RESUME}.
- Natural sub-module: `m92_cpu_pause` (pause FSM plus V/H capture and compare), exporting only paused.
- Byte-lane formatting stays inline.

## Test plan
- Unstalled run, no memrq → ce_4x_cpu every cycle; ce_cpu on every 4th cycle.
- Read at 0x01235, ram_rom_memrq, region_addr=0x0012345 → at t+1: sdr_rq toggles, sdr_wr_sel=00, sdr_addr=0x0012345. Ack with sdr_dout=0xBEEF three cycles later → rom_data=0xBEEF, mem_busy low; no ce pulses while busy.
- Write to odd 0x00101, be=01, dout=0x00AB, writable → sdr_wr_sel=10, sdr_din=0xAB00. With writable=0 → sdr_wr_sel=00.
- pf_vram_memrq read with ext_busy high 5 cycles → zero ce pulses during stall; no sdr_rq toggle.
- pause_rq during an outstanding request → paused rises only after the ack. Capture at V=100,H=200; drop pause_rq → paused falls exactly when V=100,H=200 recurs.
- Reset asserted in WAIT → all outputs at reset values next cycle; the subsequent stray ack leaves rom_data=0.
